// File: rtl/ntt_addr_seq_pkg.sv
// Shared constants and enums for the Kyber NTT address sequencer.
package ntt_pkg;

  localparam int unsigned N          = 256;
  localparam int unsigned BANKS      = 8;
  localparam int unsigned ROWS       = N / BANKS;
  localparam int unsigned NUM_STAGES = 7;
  localparam int unsigned KYBER_Q    = 3329;

  typedef enum logic {
    MODE_NTT  = 1'b0,
    MODE_INTT = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } seq_state_e;

endpackage

// File: rtl/ntt_addr_seq_delay_line.sv
// Fixed-depth shift register replaying the read strobe/addresses to the write ports.
module ntt_delay_line #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] taps [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        taps[i] <= '0;
      end
    end else begin
      taps[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/ntt_addr_seq.sv
// Stage/address sequencer for the 8-butterfly NTT core: issues read row pairs,
// len and twiddle base per cycle, and replays the rows to the write ports.
module ntt_addr_seq
  import ntt_pkg::*;
#(
  parameter int unsigned PIPE_LAT = 4,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              mode_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mode_o,
  output logic [7:0]        len_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addrA_o,
  output logic [ADDR_W-1:0] rd_addrB_o,
  output logic [6:0]        zeta_base_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addrA_o,
  output logic [ADDR_W-1:0] wr_addrB_o
);

  seq_state_e state_q, state_d;
  mode_e      mode_q, mode_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] drn_q, drn_d;
  logic [2:0] stage_q, stage_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_NTT;
      cnt_q   <= '0;
      drn_q   <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
      stage_q <= stage_d;
    end
  end

  // cnt_q parks at 15 through DRAIN so zeta_base_o keeps the stage's last value
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    stage_d = stage_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_READ;
          mode_d  = mode_e'(mode_i);
          cnt_d   = '0;
          drn_d   = '0;
          stage_d = '0;
        end
      end
      S_READ: begin
        if (cnt_q == 4'd15) begin
          state_d = S_DRAIN;
          drn_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DRAIN: begin
        if (drn_q == 4'(PIPE_LAT - 1)) begin
          if (stage_q == 3'(NUM_STAGES - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
            stage_d = stage_q + 3'd1;
            cnt_d   = '0;
          end
        end else begin
          drn_d = drn_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic              active;
  logic [2:0]        lg;
  logic [2:0]        sh;
  logic [6:0]        half;
  logic [6:0]        grp;
  logic [6:0]        zeta;
  logic [ADDR_W-1:0] c_a;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;

  // lg = log2(len); for len>=8 sh = log2(len/8), otherwise sh = log2(8/len)
  always_comb begin
    active = (state_q == S_READ) || (state_q == S_DRAIN);
    lg     = (mode_q == MODE_INTT) ? (3'd1 + stage_q) : (3'd7 - stage_q);
    half   = 7'd1 << (3'd7 - lg);
    c_a    = ADDR_W'(cnt_q);
    sh     = '0;
    grp    = '0;
    addr_a = '0;
    addr_b = '0;
    if (lg >= 3'd3) begin
      sh     = lg - 3'd3;
      grp    = 7'(cnt_q >> sh);
      addr_a = ((c_a >> sh) << (sh + 3'd1)) | (c_a & ((ADDR_W'(1) << sh) - ADDR_W'(1)));
      addr_b = addr_a + (ADDR_W'(1) << sh);
    end else begin
      sh     = 3'd3 - lg;
      grp    = 7'(cnt_q) << sh;
      addr_a = c_a << 1;
      addr_b = (c_a << 1) | ADDR_W'(1);
    end
    if (mode_q == MODE_INTT) begin
      zeta = (half << 1) - 7'd1 - grp;
    end else begin
      zeta = half + grp;
    end
  end

  assign busy_o      = active;
  assign done_o      = (state_q == S_DONE);
  assign mode_o      = (mode_q == MODE_INTT);
  assign rd_en_o     = (state_q == S_READ);
  assign len_o       = active ? (8'd1 << lg) : '0;
  assign zeta_base_o = active ? zeta : '0;
  assign rd_addrA_o  = rd_en_o ? addr_a : '0;
  assign rd_addrB_o  = rd_en_o ? addr_b : '0;

  logic [2*ADDR_W:0] wr_bus;

  ntt_delay_line #(
    .DEPTH (PIPE_LAT),
    .W     (2*ADDR_W + 1)
  ) u_wr_dly (
    .clk  (clk_i),
    .rst  (rst_i),
    .din  ({rd_en_o, rd_addrA_o, rd_addrB_o}),
    .dout (wr_bus)
  );

  assign wr_en_o    = wr_bus[2*ADDR_W];
  assign wr_addrA_o = wr_bus[2*ADDR_W-1:ADDR_W];
  assign wr_addrB_o = wr_bus[ADDR_W-1:0];

endmodule

// File: tb/tb_ntt_addr_seq.sv
// Scoreboard bench for ntt_addr_seq: expected read/write/done events are queued
// at start; a negedge monitor pops and compares them as the DUT presents them.
module tb_ntt_addr_seq;

  localparam int PL        = 4;
  localparam int ADDR_W    = 5;
  localparam int STAGE_CYC = 16 + PL;

  logic              clk = 1'b0;
  logic              rst_i, start_i, mode_i;
  logic              busy_o, done_o, mode_o, rd_en_o, wr_en_o;
  logic [7:0]        len_o;
  logic [ADDR_W-1:0] rd_addrA_o, rd_addrB_o, wr_addrA_o, wr_addrB_o;
  logic [6:0]        zeta_base_o;

  ntt_addr_seq #(
    .PIPE_LAT (PL),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .mode_i      (mode_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .mode_o      (mode_o),
    .len_o       (len_o),
    .rd_en_o     (rd_en_o),
    .rd_addrA_o  (rd_addrA_o),
    .rd_addrB_o  (rd_addrB_o),
    .zeta_base_o (zeta_base_o),
    .wr_en_o     (wr_en_o),
    .wr_addrA_o  (wr_addrA_o),
    .wr_addrB_o  (wr_addrB_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int a; int b; int zeta; int len; int inv; } rd_exp_t;
  typedef struct { int cyc; int a; int b; } wr_exp_t;
  typedef struct { int inv; int idx; int a; int b; int zeta; int len; } spot_t;

  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  int      done_q[$];
  spot_t   spots[9];

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;
  int b_lo = 1, b_hi = 0;
  int cur_inv = 0, rd_idx = 0, rd_cnt = 0, wr_cnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_one(input int c, input int a, input int b, input int z, input int len, input int inv);
    rd_exp_t r;
    wr_exp_t w;
    r = '{cyc: c, a: a, b: b, zeta: z, len: len, inv: inv};
    w = '{cyc: c + PL, a: a, b: b};
    rd_q.push_back(r);
    wr_q.push_back(w);
  endtask

  // Model enumerates butterfly blocks explicitly rather than via div/mod on c.
  task automatic push_run(input int inv, input int t0);
    int len, half, base, c, lr;
    for (int st = 0; st < 7; st++) begin
      len  = inv ? (2 << st) : (128 >> st);
      half = 128 / len;
      base = t0 + 1 + st * STAGE_CYC;
      c    = 0;
      if (len >= 8) begin
        lr = len / 8;
        for (int blk = 0; blk < 16 / lr; blk++) begin
          for (int k = 0; k < lr; k++) begin
            push_one(base + c, blk * 2 * lr + k, blk * 2 * lr + k + lr,
                     inv ? (2 * half - 1 - blk) : (half + blk), len, inv);
            c++;
          end
        end
      end else begin
        for (int cc = 0; cc < 16; cc++) begin
          push_one(base + cc, 2 * cc, 2 * cc + 1,
                   inv ? (2 * half - 1 - cc * (8 / len)) : (half + cc * (8 / len)), len, inv);
        end
      end
    end
    done_q.push_back(t0 + 7 * STAGE_CYC + 1);
  endtask

  always @(negedge clk) begin
    rd_exp_t r;
    wr_exp_t w;
    int      d;
    if (mon_en) begin
      chk("busy", busy_o, (cyc >= b_lo && cyc <= b_hi));
      if (rd_en_o) begin
        rd_cnt++;
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: got rd_en=1 expected none (cycle %0d)", cyc);
        end else begin
          r = rd_q.pop_front();
          chk("rd_cycle", cyc, r.cyc);
          chk("rd_addrA", rd_addrA_o, r.a);
          chk("rd_addrB", rd_addrB_o, r.b);
          chk("zeta_base", zeta_base_o, r.zeta);
          chk("len", len_o, r.len);
          chk("mode", mode_o, r.inv);
          foreach (spots[i]) begin
            if (spots[i].inv == cur_inv && spots[i].idx == rd_idx) begin
              chk("spot_addrA", rd_addrA_o, spots[i].a);
              chk("spot_addrB", rd_addrB_o, spots[i].b);
              chk("spot_zeta", zeta_base_o, spots[i].zeta);
              chk("spot_len", len_o, spots[i].len);
            end
          end
        end
        rd_idx++;
      end
      if (wr_en_o) begin
        wr_cnt++;
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected: got wr_en=1 expected none (cycle %0d)", cyc);
        end else begin
          w = wr_q.pop_front();
          chk("wr_cycle", cyc, w.cyc);
          chk("wr_addrA", wr_addrA_o, w.a);
          chk("wr_addrB", wr_addrB_o, w.b);
        end
      end
      if (done_o) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: got done=1 expected none (cycle %0d)", cyc);
        end else begin
          d = done_q.pop_front();
          chk("done_cycle", cyc, d);
        end
      end
    end
  end

  function automatic longint all_outs();
    return {busy_o, done_o, mode_o, len_o, rd_en_o, rd_addrA_o, rd_addrB_o,
            zeta_base_o, wr_en_o, wr_addrA_o, wr_addrB_o};
  endfunction

  task automatic run(input int inv, input int extra_start, input int rst_at);
    int t0;
    @(posedge clk); #1;
    t0      = cyc;
    cur_inv = inv;
    rd_idx  = 0;
    rd_cnt  = 0;
    wr_cnt  = 0;
    b_lo    = t0 + 1;
    b_hi    = t0 + 7 * STAGE_CYC;
    push_run(inv, t0);
    mode_i  = inv[0];
    start_i = 1'b1;
    for (int k = 1; k <= 170; k++) begin
      @(posedge clk); #1;
      mode_i  = ~inv[0];
      start_i = (extra_start != 0) && (k == extra_start || k == 7 * STAGE_CYC + 1);
      if (rst_at != 0 && k == rst_at) begin
        rst_i = 1'b1;
        b_hi  = t0 + rst_at;
      end
      if (rst_at != 0 && k == rst_at + 1) begin
        rst_i = 1'b0;
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
        chk("abort_outs_zero", all_outs(), 0);
      end
      if (rst_at == 0 && k == 7 * STAGE_CYC + 2) begin
        chk("idle_after_done", {busy_o, done_o, len_o, rd_en_o, zeta_base_o, wr_en_o}, 0);
      end
    end
    start_i = 1'b0;
    chk("pending_events", rd_q.size() + wr_q.size() + done_q.size(), 0);
    if (rst_at == 0) begin
      chk("rd_count", rd_cnt, 112);
      chk("wr_count", wr_cnt, 112);
    end
  endtask

  initial begin
    spots[0] = '{inv: 0, idx: 0,   a: 0,  b: 16, zeta: 1,   len: 128};
    spots[1] = '{inv: 0, idx: 15,  a: 15, b: 31, zeta: 1,   len: 128};
    spots[2] = '{inv: 0, idx: 24,  a: 16, b: 24, zeta: 3,   len: 64};
    spots[3] = '{inv: 0, idx: 69,  a: 10, b: 11, zeta: 21,  len: 8};
    spots[4] = '{inv: 0, idx: 83,  a: 6,  b: 7,  zeta: 38,  len: 4};
    spots[5] = '{inv: 0, idx: 111, a: 30, b: 31, zeta: 124, len: 2};
    spots[6] = '{inv: 1, idx: 0,   a: 0,  b: 1,  zeta: 127, len: 2};
    spots[7] = '{inv: 1, idx: 15,  a: 30, b: 31, zeta: 67,  len: 2};
    spots[8] = '{inv: 1, idx: 96,  a: 0,  b: 16, zeta: 1,   len: 128};

    rst_i   = 1'b1;
    start_i = 1'b0;
    mode_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs_zero", all_outs(), 0);
    rst_i  = 1'b0;
    mon_en = 1'b1;

    run(0, 0, 0);
    run(1, 50, 0);
    run(0, 0, 30);
    run(0, 0, 0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
